aes_block_packer: RTL and testbench

- Upstream input stage of the AES-128 encryption path.
- Accepts a stream of 32-bit plaintext words over a valid/ready handshake and assembles them into 128-bit blocks.
- Buffers completed blocks in a small block FIFO and presents them to the encryptor's plaintext input with a valid/ready handshake.
- Zero-pads a final partial block on word_last_i and reports how many words of that block are real.

---
 rtl/aes_block_packer.sv | 97 +++++++++
 tb/tb_aes_block_packer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/aes_block_packer.sv
// Packs 32-bit plaintext words into 128-bit AES blocks, zero-pads a final short block,
// and buffers completed blocks in a small FIFO in front of the encryptor.
module aes_block_packer #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int DEPTH   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [WORD_W-1:0]          word_i,
  input  logic                       word_valid_i,
  input  logic                       word_last_i,
  output logic                       word_ready_o,
  output logic [BLOCK_W-1:0]         block_o,
  output logic [2:0]                 block_words_o,
  output logic                       block_valid_o,
  input  logic                       block_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH+1);
  localparam int NWORDS = BLOCK_W / WORD_W;

  logic [1:0]         r_idx;
  logic [BLOCK_W-1:0] r_asm;
  logic [BLOCK_W-1:0] r_mem_data [DEPTH];
  logic [2:0]         r_mem_words [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [FILL_W-1:0]  r_fill;

  logic               w_accept;
  logic               w_complete;
  logic               w_pop;
  logic [BLOCK_W-1:0] w_block;
  logic [2:0]         w_words;

  assign word_ready_o  = (r_fill < FILL_W'(DEPTH));
  assign block_valid_o = (r_fill != '0);
  assign fill_o        = r_fill;
  assign block_o       = block_valid_o ? r_mem_data[r_rd_ptr] : '0;
  assign block_words_o = block_valid_o ? r_mem_words[r_rd_ptr] : '0;

  assign w_accept   = word_valid_i & word_ready_o;
  assign w_complete = w_accept & ((r_idx == 2'd3) | word_last_i);
  assign w_pop      = block_valid_o & block_ready_i;
  assign w_words    = {1'b0, r_idx} + 3'd1;

  // Slots below idx come from the assembly register, slot idx takes the new word,
  // slots above idx are forced to zero so a padded block carries no residue.
  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_slot
      localparam logic [1:0] SLOT = 2'(gi);
      assign w_block[BLOCK_W-1-gi*WORD_W -: WORD_W] =
        (r_idx == SLOT) ? word_i :
        (r_idx > SLOT)  ? r_asm[BLOCK_W-1-gi*WORD_W -: WORD_W] : '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_idx    <= '0;
      r_asm    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i]  <= '0;
        r_mem_words[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        if (w_complete) begin
          r_idx                  <= '0;
          r_asm                  <= '0;
          r_mem_data[r_wr_ptr]   <= w_block;
          r_mem_words[r_wr_ptr]  <= w_words;
          r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
        end else begin
          r_idx <= r_idx + 2'd1;
          r_asm <= w_block;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_complete, w_pop})
        2'b10:   r_fill <= r_fill + FILL_W'(1);
        2'b01:   r_fill <= r_fill - FILL_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of packing and FIFO occupancy.
module tb_aes_block_packer;

  localparam int DEPTH = 2;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic [31:0]  word_i = '0;
  logic         word_valid_i = 1'b0;
  logic         word_last_i = 1'b0;
  logic         word_ready_o;
  logic [127:0] block_o;
  logic [2:0]   block_words_o;
  logic         block_valid_o;
  logic         block_ready_i = 1'b0;
  logic [1:0]   fill_o;

  aes_block_packer #(.WORD_W(32), .BLOCK_W(128), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .word_i(word_i), .word_valid_i(word_valid_i),
    .word_last_i(word_last_i), .word_ready_o(word_ready_o), .block_o(block_o),
    .block_words_o(block_words_o), .block_valid_o(block_valid_o),
    .block_ready_i(block_ready_i), .fill_o(fill_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [127:0] data;
    logic [2:0]   words;
  } blk_t;

  blk_t        m_q[$];
  logic [31:0] m_cur[$];
  int          checks = 0;
  int          failures = 0;
  bit          last_acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    blk_t head;
    chk("fill", 128'(fill_o), 128'(m_q.size()));
    chk("block_valid", 128'(block_valid_o), 128'(m_q.size() != 0));
    chk("word_ready", 128'(word_ready_o), 128'(m_q.size() < DEPTH));
    if (m_q.size() != 0) head = m_q[0];
    else begin head.data = '0; head.words = '0; end
    chk("block_o", block_o, head.data);
    chk("block_words", 128'(block_words_o), 128'(head.words));
  endtask

  // One clock: predict accept/pop from the model, advance it on the edge, check at negedge.
  task automatic do_cycle();
    bit   acc, pop;
    blk_t b;
    acc = word_valid_i && (m_q.size() < DEPTH);
    pop = block_ready_i && (m_q.size() != 0);
    @(posedge clk_i);
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_cur.push_back(word_i);
      if (m_cur.size() == 4 || word_last_i) begin
        b.data = '0;
        for (int i = 0; i < m_cur.size(); i++) b.data[127-32*i -: 32] = m_cur[i];
        b.words = 3'(m_cur.size());
        m_q.push_back(b);
        m_cur.delete();
      end
    end
    last_acc = acc;
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input logic br);
    bit done = 0;
    word_i = w; word_last_i = last; word_valid_i = 1'b1; block_ready_i = br;
    for (int n = 0; n < 40 && !done; n++) begin
      do_cycle();
      done = last_acc;
    end
    chk("accept_timeout", 128'(done), 128'(1));
    word_valid_i = 1'b0; word_last_i = 1'b0;
  endtask

  task automatic idle(input int n, input logic br);
    block_ready_i = br;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  initial begin
    // Reset
    #12;
    chk("rst_valid", 128'(block_valid_o), 128'(0));
    chk("rst_block", block_o, 128'(0));
    chk("rst_words", 128'(block_words_o), 128'(0));
    chk("rst_fill", 128'(fill_o), 128'(0));
    chk("rst_ready", 128'(word_ready_o), 128'(1));
    @(negedge clk_i); rst_n_i = 1'b1;
    @(negedge clk_i);

    // Test 1: full block with downstream always ready
    send_word(32'h00112233, 0, 1);
    send_word(32'h44556677, 0, 1);
    send_word(32'h8899AABB, 0, 1);
    send_word(32'hCCDDEEFF, 0, 1);
    chk("t1_block", block_o, 128'h00112233445566778899AABBCCDDEEFF);
    chk("t1_words", 128'(block_words_o), 128'(4));
    chk("t1_valid", 128'(block_valid_o), 128'(1));
    idle(1, 1);
    chk("t1_valid_gone", 128'(block_valid_o), 128'(0));
    chk("t1_fill", 128'(fill_o), 128'(0));

    // Test 2: padded block, then a full block with no residue
    send_word(32'hDEADBEEF, 0, 1);
    send_word(32'h01020304, 1, 1);
    chk("t2_block", block_o, 128'hDEADBEEF010203040000000000000000);
    chk("t2_words", 128'(block_words_o), 128'(2));
    send_word(32'h11111111, 0, 1);
    send_word(32'h22222222, 0, 1);
    send_word(32'h33333333, 0, 1);
    send_word(32'h44444444, 0, 1);
    chk("t2_block2", block_o, 128'h11111111222222223333333344444444);
    idle(2, 1);

    // Test 3: backpressure, 12 words, FIFO fills after 8
    for (int i = 0; i < 8; i++) send_word(32'hA0000000 + 32'(i), 0, 0);
    chk("t3_fill", 128'(fill_o), 128'(2));
    chk("t3_ready", 128'(word_ready_o), 128'(0));
    word_i = 32'hA0000008; word_valid_i = 1'b1;
    idle(3, 0);
    chk("t3_stall_fill", 128'(fill_o), 128'(2));
    for (int i = 8; i < 12; i++) send_word(32'hA0000000 + 32'(i), 0, 1);
    idle(4, 1);
    chk("t3_drained", 128'(fill_o), 128'(0));

    // Test 4: push and pop on the same edge at fill 1
    for (int i = 0; i < 4; i++) send_word(32'hB0000000 + 32'(i), 0, 0);
    for (int i = 4; i < 7; i++) send_word(32'hB0000000 + 32'(i), 0, 0);
    send_word(32'hB0000007, 0, 1);
    chk("t4_fill", 128'(fill_o), 128'(1));
    chk("t4_block", block_o, 128'hB0000004B0000005B0000006B0000007);
    idle(2, 1);

    // Test 5: asynchronous reset with 1 buffered block and 2 partial words
    for (int i = 0; i < 6; i++) send_word(32'hC0000000 + 32'(i), 0, 0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("t5_valid", 128'(block_valid_o), 128'(0));
    chk("t5_block", block_o, 128'(0));
    chk("t5_fill", 128'(fill_o), 128'(0));
    m_q.delete(); m_cur.delete();
    @(negedge clk_i); #2 rst_n_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) send_word(32'hD0000000 + 32'(i), 0, 1);
    chk("t5_fresh", block_o, 128'hD0000000D0000001D0000002D0000003);
    idle(2, 1);

    // Test 6: single-word message
    send_word(32'hA5A5A5A5, 1, 1);
    chk("t6_block", block_o, {32'hA5A5A5A5, 96'h0});
    chk("t6_words", 128'(block_words_o), 128'(1));
    idle(2, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      word_i        = $urandom;
      word_valid_i  = ($urandom_range(0, 3) != 0);
      word_last_i   = ($urandom_range(0, 5) == 0);
      block_ready_i = ($urandom_range(0, 1) == 1);
      do_cycle();
    end
    word_valid_i = 1'b0; word_last_i = 1'b0;
    send_word(32'hFFFFFFFF, 1, 1);
    idle(4, 1);
    chk("final_empty", 128'(fill_o), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
